data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder side of the core's data-memory request/acknowledge handshake.
- The execute stage raises a one-cycle `req` with `we`/`addr`/`wdata`; this block performs a word access on an internal block RAM and returns a one-cycle `done` with `rdata`/`err`.
- Sits between the multi-cycle CPU's EXECUTE_WAIT state and on-chip BRAM; replaces the behavioural data memory.

Parameters:
- LEN_WORD, 32, data word width in bits.
- LEN_ADDR, 32, byte-address width.
- DEPTH_LOG2, 15, log2 of memory depth in words (32768 words = 128 KiB).
- READ_LATENCY, 2, BRAM cycles from address presented to read data valid; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on posedge.
- rstn  in  1  synchronous, active-low reset.
- req  in  1  access request; one-cycle pulse; sampled only when busy=0.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  LEN_ADDR  byte address; sampled with req.
- wdata  in  LEN_WORD  store data; sampled with req.
- busy  out  1  high from the cycle after an accepted req through the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- rdata  out  LEN_WORD  load data; valid when done=1 for a successful load; held until the next successful load's done.
- err  out  1  access fault; valid only with done, 0 otherwise.

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; busy=0, done=0, err=0, rdata=0.
  - Any in-flight access is aborted; no done is issued for it.
  - A store whose write cycle coincides with reset is suppressed.
  - BRAM contents are not cleared.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Misaligned when addr[1:0] != 0.
  - Out of range when addr[LEN_ADDR-1:DEPTH_LOG2+2] != 0.
  - Either fault gives fault=1.
- Request capture: at a posedge with state IDLE and req=1, latch we, word index, wdata and fault; go to ACCESS. req while busy=1 is ignored.
- State machine (one-hot: IDLE, ACCESS, RD_WAIT, DONE):
  - IDLE: busy=0. On req, go to ACCESS.
  - ACCESS, fault=1: no BRAM enable; go to DONE with err staged to 1.
  - ACCESS, store: BRAM write enable asserted this cycle; go to DONE.
  - ACCESS, load: BRAM read issued; latency counter loaded with READ_LATENCY-1; go to RD_WAIT, or to DONE directly if READ_LATENCY=1.
  - RD_WAIT: decrement counter; when it reaches 0, capture BRAM output into rdata and go to DONE.
  - DONE: done=1 for exactly this cycle; err=fault; return to IDLE.
- Latency, with req sampled at edge T:
  - Store or fault: done high in cycle T+2.
  - Load: done high in cycle T+1+READ_LATENCY (T+3 at default).
- Back-to-back requests:
  - A new req is accepted no earlier than the cycle after done (i.e. in IDLE).
  - Minimum request spacing: 3 cycles for stores, 2+READ_LATENCY for loads.
- Data rules:
  - Stores write the full LEN_WORD; no byte enables.
  - A faulted store writes nothing.
  - A faulted load leaves rdata unchanged.
  - Load after store to the same word returns the new data (write completes before the next request can be accepted).
- Reset mid-operation: at any state, returns to IDLE next cycle with the reset values above; the first req after reset is accepted normally.

Test Plan:
- Reset, then store: after reset, store req we=1 addr=0x0000_0010 wdata=0xDEAD_BEEF at T -> done=1, err=0 in T+2 only; busy high T+1..T+2.
- Load after store: load req addr=0x0000_0010 at T -> done=1 in T+3 (READ_LATENCY=2) with rdata=0xDEAD_BEEF, err=0; rdata still 0xDEAD_BEEF 5 cycles later.
- Boundary and fault accesses:
  - Store/load at 0x0001_FFFC with 0x1234_5678 -> read back 0x1234_5678.
  - Load at 0x0002_0000 -> done in T+2 with err=1, rdata unchanged.
  - Store at 0x0000_0012 -> err=1, and a subsequent load of word 0x10 still returns 0xDEAD_BEEF.
- Request while busy: pulse a second req (store 0x20, 0xFFFF_FFFF) one cycle after an accepted load -> only one done; a later load of 0x20 returns the prior contents (0 after fresh init).
- Reset mid-load: assert rstn=0 in cycle T+1 after a load req -> no done is ever issued; busy=0, rdata=0 after reset; the next load completes normally.
- Latency sweep: READ_LATENCY=1 and 4 -> load done at T+2 and T+5 respectively; store done at T+2 in both.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory request/acknowledge bus between the execute stage (master)
// and the memory responder (slave). One-cycle req in, one-cycle done out.
interface data_mem_responder_if #(
    parameter int LEN_WORD = 32,
    parameter int LEN_ADDR = 32
);
    logic                req;
    logic                we;
    logic [LEN_ADDR-1:0] addr;
    logic [LEN_WORD-1:0] wdata;
    logic                busy;
    logic                done;
    logic [LEN_WORD-1:0] rdata;
    logic                err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  busy,
        input  done,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output busy,
        output done,
        output rdata,
        output err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a one-cycle word access request, performs it
// on an internal block RAM and answers with a one-cycle done pulse carrying
// rdata/err. Misaligned or out-of-range addresses fault without touching RAM.
// READ_LATENCY must lie in 1..4; LEN_ADDR must exceed DEPTH_LOG2+2.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for req; busy low
// ACCESS  | RAM write (store) or read issue (load); faults skip the RAM
// RD_WAIT | counting down remaining read latency, then capture rdata
// DONE    | done pulse with err; back to IDLE next cycle
module data_mem_responder #(
    parameter int LEN_WORD     = 32,
    parameter int LEN_ADDR     = 32,
    parameter int DEPTH_LOG2   = 15,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    data_mem_responder_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ACCESS  = 4'b0010,
        S_RD_WAIT = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t                r_state;
    logic                  r_we;
    logic                  r_fault;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [LEN_WORD-1:0]   r_wdata;
    logic [1:0]            r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_WORD-1:0]   r_rdata;

    logic [LEN_WORD-1:0]   r_mem [0:DEPTH-1];

    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic                  w_mem_we;
    logic [LEN_WORD-1:0]   w_rd_src;

    assign w_misalign     = |bus.addr[1:0];
    assign w_out_of_range = |bus.addr[LEN_ADDR-1:DEPTH_LOG2+2];
    assign w_fault        = w_misalign | w_out_of_range;

    // Gating with rstn drops a store whose write cycle coincides with reset.
    assign w_mem_we = rstn && (r_state == S_ACCESS) && r_we && !r_fault;

    // Block RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Read path: with latency 1 the rdata register is the RAM output register;
    // longer latencies add RAM output pipeline stages ahead of it.
    generate
        if (READ_LATENCY == 1) begin : g_rd_direct
            assign w_rd_src = r_mem[r_idx];
        end else begin : g_rd_pipe
            logic [LEN_WORD-1:0] r_pipe [0:READ_LATENCY-2];

            // RAM read pipeline; free-running, only sampled at the capture point.
            always_ff @(posedge clk) begin
                r_pipe[0] <= r_mem[r_idx];
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_rd_src = r_pipe[READ_LATENCY-2];
        end
    endgenerate

    // Access sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_idx   <= bus.addr[DEPTH_LOG2+1:2];
                        r_wdata <= bus.wdata;
                        r_fault <= w_fault;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_fault || r_we) begin
                        r_err   <= r_fault;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (READ_LATENCY == 1) begin
                        r_rdata <= w_rd_src;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= CNT_INIT;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Counter reaching zero on this decrement marks read data valid.
                    if (r_cnt == 2'd1) begin
                        r_cnt   <= 2'd0;
                        r_rdata <= w_rd_src;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (READ_LATENCY 2, 1, 4) driven
// by identical stimulus; each answer is compared with a word-array model.
module tb_data_mem_responder;

    logic        clk;
    logic        rstn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    int n_vec;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if u_if0 ();
    data_mem_responder_if u_if1 ();
    data_mem_responder_if u_if2 ();

    assign u_if0.req = req;  assign u_if0.we = we;  assign u_if0.addr = addr;  assign u_if0.wdata = wdata;
    assign u_if1.req = req;  assign u_if1.we = we;  assign u_if1.addr = addr;  assign u_if1.wdata = wdata;
    assign u_if2.req = req;  assign u_if2.we = we;  assign u_if2.addr = addr;  assign u_if2.wdata = wdata;

    data_mem_responder #(.READ_LATENCY(2)) u_dut0 (.clk(clk), .rstn(rstn), .bus(u_if0.slave));
    data_mem_responder #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(u_if1.slave));
    data_mem_responder #(.READ_LATENCY(4)) u_dut2 (.clk(clk), .rstn(rstn), .bus(u_if2.slave));

    logic        o_busy  [3];
    logic        o_done  [3];
    logic        o_err   [3];
    logic [31:0] o_rdata [3];

    assign o_busy[0] = u_if0.busy;  assign o_done[0] = u_if0.done;  assign o_err[0] = u_if0.err;  assign o_rdata[0] = u_if0.rdata;
    assign o_busy[1] = u_if1.busy;  assign o_done[1] = u_if1.done;  assign o_err[1] = u_if1.err;  assign o_rdata[1] = u_if1.rdata;
    assign o_busy[2] = u_if2.busy;  assign o_done[2] = u_if2.done;  assign o_err[2] = u_if2.err;  assign o_rdata[2] = u_if2.rdata;

    function automatic int rl_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    // Reference model: byte-addressed 128 KiB memory seen as words.
    logic [31:0] m_mem [int];
    logic [31:0] m_rd;
    bit          m_known;

    function automatic void model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     output bit f);
        int idx;
        f   = (a % 4 != 0) || (a >= 32'h0002_0000);
        idx = int'(a / 4);
        if (!f && w) begin
            m_mem[idx] = d;
        end else if (!f) begin
            if (m_mem.exists(idx)) begin
                m_rd    = m_mem[idx];
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
    endfunction

    // Per-instance observations of the last access (cycle k = k-th cycle after req sampled).
    int          ob_ndone [3];
    int          ob_donek [3];
    logic        ob_err   [3];
    logic [31:0] ob_rd    [3];
    logic [31:0] ob_hold  [3];
    logic [15:0] ob_busy  [3];

    // mode 0: plain access; 1: extra store req while busy; 2: reset during cycle 1.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d, input int mode);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ob_ndone[i] = 0; ob_donek[i] = -1; ob_err[i] = 1'b0;
            ob_rd[i] = '0; ob_hold[i] = '0; ob_busy[i] = '0;
        end
        for (int k = 1; k <= 10; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (o_busy[i]) ob_busy[i][k] = 1'b1;
                if (o_done[i]) begin
                    ob_ndone[i]++;
                    if (ob_donek[i] < 0) begin
                        ob_donek[i] = k;
                        ob_err[i]   = o_err[i];
                        ob_rd[i]    = o_rdata[i];
                    end
                end
                if (k == 10) ob_hold[i] = o_rdata[i];
            end
            if (mode == 1 && k == 1) begin
                req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF;
            end
            if (mode == 1 && k == 2) req = 1'b0;
            if (mode == 2 && k == 1) rstn = 1'b0;
            if (mode == 2 && k == 2) rstn = 1'b1;
            if (k < 10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (o_busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %b want 0", i, o_busy[i]); end
            n_vec++; if (o_done[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d got %b want 0", i, o_done[i]); end
            n_vec++; if (o_err[i]  !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d got %b want 0", i, o_err[i]); end
            n_vec++; if (o_rdata[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d got %h want 0", i, o_rdata[i]); end
        end
        rstn = 1'b1;
        m_rd = '0; m_known = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    task automatic test_store_load();
        op_t tbl [9];
        bit  f;
        tbl = '{
            '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF},
            '{1'b0, 32'h0000_0010, 32'h0},
            '{1'b1, 32'h0001_FFFC, 32'h1234_5678},
            '{1'b0, 32'h0001_FFFC, 32'h0},
            '{1'b0, 32'h0002_0000, 32'h0},
            '{1'b1, 32'h0000_0012, 32'hCAFE_0000},
            '{1'b0, 32'h0000_0010, 32'h0},
            '{1'b0, 32'h8000_0010, 32'h0},
            '{1'b0, 32'h0000_0003, 32'h0}
        };
        foreach (tbl[t]) begin
            model_op(tbl[t].w, tbl[t].a, tbl[t].d, f);
            do_access(tbl[t].w, tbl[t].a, tbl[t].d, 0);
            for (int i = 0; i < 3; i++) begin
                int          ek;
                logic [15:0] eb;
                ek = (f || tbl[t].w) ? 2 : 1 + rl_of(i);
                eb = '0;
                for (int k = 1; k <= ek; k++) eb[k] = 1'b1;
                n_vec++; if (ob_ndone[i] != 1) begin n_fail++; $display("FAIL dir_ndone op%0d dut%0d got %0d want 1", t, i, ob_ndone[i]); end
                n_vec++; if (ob_donek[i] != ek) begin n_fail++; $display("FAIL dir_latency op%0d dut%0d got %0d want %0d", t, i, ob_donek[i], ek); end
                n_vec++; if (ob_err[i] !== logic'(f)) begin n_fail++; $display("FAIL dir_err op%0d dut%0d got %b want %b", t, i, ob_err[i], f); end
                n_vec++; if (ob_busy[i] !== eb) begin n_fail++; $display("FAIL dir_busy op%0d dut%0d got %h want %h", t, i, ob_busy[i], eb); end
                if (m_known) begin
                    n_vec++; if (ob_rd[i] !== m_rd) begin n_fail++; $display("FAIL dir_rdata op%0d dut%0d got %h want %h", t, i, ob_rd[i], m_rd); end
                    n_vec++; if (ob_hold[i] !== m_rd) begin n_fail++; $display("FAIL dir_hold op%0d dut%0d got %h want %h", t, i, ob_hold[i], m_rd); end
                end
            end
        end
    endtask

    task automatic test_busy_req();
        bit f;
        model_op(1'b1, 32'h0000_0020, 32'h0BAD_F00D, f);
        do_access(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 0);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ob_ndone[i] != 1) begin n_fail++; $display("FAIL busy_prestore dut%0d got %0d dones want 1", i, ob_ndone[i]); end
        end
        model_op(1'b0, 32'h0000_0010, 32'h0, f);
        do_access(1'b0, 32'h0000_0010, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ob_ndone[i] != 1) begin n_fail++; $display("FAIL busy_ndone dut%0d got %0d want 1", i, ob_ndone[i]); end
            n_vec++; if (ob_rd[i] !== m_rd) begin n_fail++; $display("FAIL busy_rdata dut%0d got %h want %h", i, ob_rd[i], m_rd); end
        end
        model_op(1'b0, 32'h0000_0020, 32'h0, f);
        do_access(1'b0, 32'h0000_0020, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ob_rd[i] !== m_rd) begin n_fail++; $display("FAIL busy_ignored_store dut%0d got %h want %h", i, ob_rd[i], m_rd); end
        end
    endtask

    task automatic test_reset_mid();
        bit f;
        // Aborted load, then aborted store (write suppressed), then a normal load.
        for (int s = 0; s < 2; s++) begin
            if (s == 0) do_access(1'b0, 32'h0001_FFFC, 32'h0, 2);
            else        do_access(1'b1, 32'h0000_0010, 32'h55AA_55AA, 2);
            m_rd = '0; m_known = 1'b1;
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (ob_ndone[i] != 0) begin n_fail++; $display("FAIL rstmid_ndone s%0d dut%0d got %0d want 0", s, i, ob_ndone[i]); end
                n_vec++; if (ob_busy[i] !== 16'h0002) begin n_fail++; $display("FAIL rstmid_busy s%0d dut%0d got %h want 0002", s, i, ob_busy[i]); end
                n_vec++; if (ob_hold[i] !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata s%0d dut%0d got %h want 0", s, i, ob_hold[i]); end
            end
        end
        model_op(1'b0, 32'h0000_0010, 32'h0, f);
        do_access(1'b0, 32'h0000_0010, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ob_donek[i] != 1 + rl_of(i)) begin n_fail++; $display("FAIL rstmid_next_latency dut%0d got %0d want %0d", i, ob_donek[i], 1 + rl_of(i)); end
            n_vec++; if (ob_rd[i] !== m_rd) begin n_fail++; $display("FAIL rstmid_next_rdata dut%0d got %h want %h", i, ob_rd[i], m_rd); end
        end
    endtask

    task automatic test_random();
        logic [31:0] wr_q [$];
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        bit          f;
        int          r;
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            d = $urandom();
            if (r <= 3 || (r <= 6 && wr_q.size() == 0)) begin
                w = 1'b1;
                if (wr_q.size() != 0 && $urandom_range(0, 1) == 0)
                    a = wr_q[$urandom_range(0, wr_q.size() - 1)];
                else begin
                    a = 32'($urandom_range(0, 32767)) * 4;
                    wr_q.push_back(a);
                end
            end else if (r <= 6) begin
                w = 1'b0;
                a = wr_q[$urandom_range(0, wr_q.size() - 1)];
            end else begin
                w = logic'($urandom_range(0, 1));
                if (r == 7) a = 32'($urandom_range(0, 32767)) * 4 + 32'($urandom_range(1, 3));
                else        a = $urandom() | 32'h0002_0000;
            end
            model_op(w, a, d, f);
            do_access(w, a, d, 0);
            for (int i = 0; i < 3; i++) begin
                int          ek;
                logic [15:0] eb;
                ek = (f || w) ? 2 : 1 + rl_of(i);
                eb = '0;
                for (int k = 1; k <= ek; k++) eb[k] = 1'b1;
                n_vec++; if (ob_ndone[i] != 1) begin n_fail++; $display("FAIL rnd_ndone op%0d dut%0d addr %h got %0d want 1", t, i, a, ob_ndone[i]); end
                n_vec++; if (ob_donek[i] != ek) begin n_fail++; $display("FAIL rnd_latency op%0d dut%0d addr %h got %0d want %0d", t, i, a, ob_donek[i], ek); end
                n_vec++; if (ob_err[i] !== logic'(f)) begin n_fail++; $display("FAIL rnd_err op%0d dut%0d addr %h got %b want %b", t, i, a, ob_err[i], f); end
                n_vec++; if (ob_busy[i] !== eb) begin n_fail++; $display("FAIL rnd_busy op%0d dut%0d got %h want %h", t, i, ob_busy[i], eb); end
                if (m_known) begin
                    n_vec++; if (ob_rd[i] !== m_rd) begin n_fail++; $display("FAIL rnd_rdata op%0d dut%0d addr %h got %h want %h", t, i, a, ob_rd[i], m_rd); end
                end
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rstn   = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        test_reset();
        test_store_load();
        test_busy_req();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
